// File: rtl/regfile_sb_if.sv
// Issue/write-back bus of the register file with scoreboard.
// The master side is the decode/issue stage; the slave side is regfile_sb.
interface regfile_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NREAD    = 4,
    parameter int NWRITE   = 2,
    parameter int NISSUE   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NREAD-1:0][AW-1:0]      ra;
    logic [NREAD-1:0][DATA_W-1:0]  rd;
    logic [NREAD-1:0]              rd_ready;
    logic [NWRITE-1:0]             we;
    logic [NWRITE-1:0][AW-1:0]     wa;
    logic [NWRITE-1:0][DATA_W-1:0] wd;
    logic [NISSUE-1:0]             set_en;
    logic [NISSUE-1:0][AW-1:0]     set_addr;
    logic                          flush;
    logic [NUM_REGS-1:0]           busy;

    modport master (
        output ra, we, wa, wd, set_en, set_addr, flush,
        input  rd, rd_ready, busy
    );

    modport slave (
        input  ra, we, wa, wd, set_en, set_addr, flush,
        output rd, rd_ready, busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file (x0 hardwired to zero) with write-through reads
// and a per-register busy scoreboard for the multi-issue stage.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NREAD    = 4,
    parameter int NWRITE   = 2,
    parameter int NISSUE   = 2
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs     [1:NUM_REGS-1];
    logic [DATA_W-1:0]   regs_nxt [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] clr;
    logic [NUM_REGS-1:0] set;
    logic [NUM_REGS-1:0] busy_q;

    // Out-of-range addresses never match any r, so they are dropped for free.
    always_comb begin : write_merge
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        clr = '0;
        set = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            regs_nxt[r] = regs[r];
            for (int j = 0; j < NWRITE; j++) begin
                if (bus.we[j] && bus.wa[j] == AW'(r)) begin
                    regs_nxt[r] = bus.wd[j];
                    clr[r]      = 1'b1;
                end
            end
            for (int k = 0; k < NISSUE; k++) begin
                if (bus.set_en[k] && bus.set_addr[k] == AW'(r)) begin
                    set[r] = 1'b1;
                end
            end
        end
    end

    // Ready ignores this cycle's set but honours this cycle's write-back.
    always_comb begin : read_ports
        bus.rd       = '0;
        bus.rd_ready = '1;
        for (int i = 0; i < NREAD; i++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.ra[i] == AW'(r)) begin
                    bus.rd[i]       = regs_nxt[r];
                    bus.rd_ready[i] = !(busy_q[r] && !clr[r]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin : reg_store
        // NOTE: the register array is reset on purpose: software relies on all registers reading 0 after reset.
        if (reset) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs[r] <= regs_nxt[r];
            end
        end
    end

    // Set beats clear so a re-issue in the write-back cycle stays busy.
    always_ff @(posedge clk) begin : scoreboard
        // NOTE: non-blocking assignments in clocked blocks keep every flop sampling pre-edge values.
        if (reset || bus.flush) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr) | set;
        end
    end

    assign bus.busy = busy_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int NREAD    = 4;
    localparam int NWRITE   = 2;
    localparam int NISSUE   = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    regfile_sb_if #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NREAD(NREAD),
        .NWRITE(NWRITE), .NISSUE(NISSUE)
    ) bus ();

    regfile_sb #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NREAD(NREAD),
        .NWRITE(NWRITE), .NISSUE(NISSUE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.ra       = '0;
        bus.we       = '0;
        bus.wa       = '0;
        bus.wd       = '0;
        bus.set_en   = '0;
        bus.set_addr = '0;
        bus.flush    = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        for (int i = 0; i < NREAD; i++) bus.ra[i] = 5'(i);
        #1;
        for (int i = 0; i < NREAD; i++) begin
            total++;
            if (bus.rd[i] !== 32'h0 || bus.rd_ready[i] !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold_port%0d: rd=%h ready=%b want rd=0 ready=1", i, bus.rd[i], bus.rd_ready[i]);
            end
        end
        total++;
        if (bus.busy !== 32'h0) begin
            bad++;
            $display("FAIL reset_busy: got %h want 0", bus.busy);
        end
        tick();
        reset = 1'b0;
        tick();
        #1;
        for (int i = 0; i < NREAD; i++) begin
            total++;
            if (bus.rd[i] !== 32'h0 || bus.rd_ready[i] !== 1'b1) begin
                bad++;
                $display("FAIL reset_after_port%0d: rd=%h ready=%b want rd=0 ready=1", i, bus.rd[i], bus.rd_ready[i]);
            end
        end
    endtask

    task automatic test_set_clear();
        idle();
        bus.set_en[0]   = 1'b1;
        bus.set_addr[0] = 5'd5;
        tick();
        idle();
        bus.ra[0] = 5'd5;
        #1;
        total++;
        if (bus.rd_ready[0] !== 1'b0 || bus.busy[5] !== 1'b1) begin
            bad++;
            $display("FAIL set_x5: ready=%b busy5=%b want ready=0 busy5=1", bus.rd_ready[0], bus.busy[5]);
        end
        tick();
        bus.we[0] = 1'b1;
        bus.wa[0] = 5'd5;
        bus.wd[0] = 32'hDEAD_BEEF;
        #1;
        total++;
        if (bus.rd[0] !== 32'hDEAD_BEEF || bus.rd_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL writeback_x5: rd=%h ready=%b want rd=deadbeef ready=1", bus.rd[0], bus.rd_ready[0]);
        end
        tick();
        idle();
        bus.ra[3] = 5'd5;
        #1;
        total++;
        if (bus.busy[5] !== 1'b0 || bus.rd[3] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL after_wb_x5: busy5=%b rd=%h want busy5=0 rd=deadbeef", bus.busy[5], bus.rd[3]);
        end
    endtask

    task automatic test_write_conflict();
        idle();
        bus.we    = 2'b11;
        bus.wa[0] = 5'd7;
        bus.wa[1] = 5'd7;
        bus.wd[0] = 32'h11;
        bus.wd[1] = 32'h22;
        bus.ra[1] = 5'd7;
        #1;
        total++;
        if (bus.rd[1] !== 32'h22) begin
            bad++;
            $display("FAIL conflict_same_cycle: got %h want 22", bus.rd[1]);
        end
        tick();
        idle();
        bus.ra[1] = 5'd7;
        #1;
        total++;
        if (bus.rd[1] !== 32'h22) begin
            bad++;
            $display("FAIL conflict_stored: got %h want 22", bus.rd[1]);
        end
    endtask

    task automatic test_x0();
        idle();
        bus.we[0]       = 1'b1;
        bus.wa[0]       = 5'd0;
        bus.wd[0]       = 32'hFFFF_FFFF;
        bus.set_en[0]   = 1'b1;
        bus.set_addr[0] = 5'd0;
        bus.ra[2]       = 5'd0;
        #1;
        total++;
        if (bus.rd[2] !== 32'h0 || bus.rd_ready[2] !== 1'b1) begin
            bad++;
            $display("FAIL x0_write_through: rd=%h ready=%b want rd=0 ready=1", bus.rd[2], bus.rd_ready[2]);
        end
        tick();
        idle();
        bus.ra[2] = 5'd0;
        #1;
        total++;
        if (bus.rd[2] !== 32'h0 || bus.busy !== 32'h0) begin
            bad++;
            $display("FAIL x0_after: rd=%h busy=%h want rd=0 busy=0", bus.rd[2], bus.busy);
        end
    endtask

    task automatic test_set_clr_flush();
        idle();
        bus.set_en[0]   = 1'b1;
        bus.set_addr[0] = 5'd9;
        bus.we[1]       = 1'b1;
        bus.wa[1]       = 5'd9;
        bus.wd[1]       = 32'h99;
        bus.ra[0]       = 5'd9;
        #1;
        total++;
        if (bus.rd[0] !== 32'h99 || bus.rd_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL set_clr_x9_read: rd=%h ready=%b want rd=99 ready=1", bus.rd[0], bus.rd_ready[0]);
        end
        tick();
        idle();
        total++;
        if (bus.busy[9] !== 1'b1) begin
            bad++;
            $display("FAIL set_clr_x9_busy: got %b want 1", bus.busy[9]);
        end
        bus.we[0] = 1'b1;
        bus.wa[0] = 5'd9;
        bus.wd[0] = 32'h98;
        tick();
        idle();
        total++;
        if (bus.busy[9] !== 1'b0) begin
            bad++;
            $display("FAIL clr_x9_busy: got %b want 0", bus.busy[9]);
        end
        bus.set_en[1]   = 1'b1;
        bus.set_addr[1] = 5'd9;
        bus.flush       = 1'b1;
        tick();
        idle();
        total++;
        if (bus.busy[9] !== 1'b0) begin
            bad++;
            $display("FAIL flush_set_x9_busy: got %b want 0", bus.busy[9]);
        end
    endtask

    task automatic test_flush();
        idle();
        bus.we    = 2'b11;
        bus.wa[0] = 5'd6;
        bus.wd[0] = 32'h66;
        bus.wa[1] = 5'd4;
        bus.wd[1] = 32'h44;
        tick();
        idle();
        bus.set_en      = 2'b11;
        bus.set_addr[0] = 5'd3;
        bus.set_addr[1] = 5'd4;
        tick();
        idle();
        bus.set_en[1]   = 1'b1;
        bus.set_addr[1] = 5'd6;
        tick();
        idle();
        total++;
        if (bus.busy !== 32'h0000_0058) begin
            bad++;
            $display("FAIL busy_x3_x4_x6: got %h want 00000058", bus.busy);
        end
        bus.flush = 1'b1;
        bus.we[0] = 1'b1;
        bus.wa[0] = 5'd3;
        bus.wd[0] = 32'h33;
        tick();
        idle();
        bus.ra[0] = 5'd3;
        bus.ra[1] = 5'd4;
        bus.ra[2] = 5'd6;
        bus.ra[3] = 5'd7;
        #1;
        total++;
        if (bus.busy !== 32'h0) begin
            bad++;
            $display("FAIL flush_busy: got %h want 0", bus.busy);
        end
        total++;
        if (bus.rd[0] !== 32'h33 || bus.rd[1] !== 32'h44 || bus.rd[2] !== 32'h66 || bus.rd[3] !== 32'h22) begin
            bad++;
            $display("FAIL flush_data: got %h %h %h %h want 33 44 66 22", bus.rd[0], bus.rd[1], bus.rd[2], bus.rd[3]);
        end
        total++;
        if (bus.rd_ready !== 4'hF) begin
            bad++;
            $display("FAIL flush_ready: got %b want 1111", bus.rd_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        idle();
        reset           = 1'b1;
        bus.we[0]       = 1'b1;
        bus.wa[0]       = 5'd4;
        bus.wd[0]       = 32'h55;
        bus.set_en[0]   = 1'b1;
        bus.set_addr[0] = 5'd4;
        tick();
        reset = 1'b0;
        idle();
        bus.ra[0] = 5'd4;
        bus.ra[1] = 5'd6;
        #1;
        total++;
        if (bus.rd[0] !== 32'h0 || bus.rd[1] !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_write_data: x4=%h x6=%h want 0 0", bus.rd[0], bus.rd[1]);
        end
        total++;
        if (bus.busy !== 32'h0 || bus.rd_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_write_busy: busy=%h ready=%b want busy=0 ready=1", bus.busy, bus.rd_ready[0]);
        end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_write_conflict();
        test_x0();
        test_set_clr_flush();
        test_flush();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
